// File: rtl/vga_pkg.sv
// Shared video types and constants for the sprite compositing pipeline.
// palette_color() defines the fixed 16-entry sprite palette; wider indices wrap.
package vga_pkg;

  typedef logic [23:0] color_t;  // R [23:16], G [15:8], B [7:0]

  localparam color_t TRANSPARENT_KEY_DEF = 24'hF442EE;
  localparam color_t BG_COLOR_DEF        = 24'h0000F0;
  localparam int     PIPE_LAT            = 3;

  function automatic color_t palette_color(input int unsigned idx);
    case (idx % 16)
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'hF442EE;
      3:       return 24'hFF0000;
      4:       return 24'h0000FF;
      5:       return 24'h00FF00;
      6:       return 24'hFFFF00;
      7:       return 24'h00FFFF;
      8:       return 24'hFF00FF;
      9:       return 24'h808080;
      10:      return 24'h804000;
      11:      return 24'h408000;
      12:      return 24'h004080;
      13:      return 24'hC0C0C0;
      14:      return 24'h102030;
      15:      return 24'hF442EE;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/palette_lut.sv
// Synchronous single-read-port palette ROM, 2^INDEX_W x 24, one-cycle read latency.
module palette_lut
  import vga_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  output color_t             color
);

  color_t rom [2**INDEX_W];

  for (genvar gi = 0; gi < 2**INDEX_W; gi++) begin : g_rom
    assign rom[gi] = palette_color(gi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) color <= '0;
    else        color <= rom[index];
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: input register, per-layer palette lookup,
// then priority select, blanking and sticky per-frame collision detection.
module sprite_compositor
  import vga_pkg::*;
#(
  parameter int     NUM_LAYERS      = 2,
  parameter int     INDEX_W         = 4,
  parameter color_t TRANSPARENT_KEY = TRANSPARENT_KEY_DEF,
  parameter color_t BG_COLOR        = BG_COLOR_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*INDEX_W-1:0] layer_index,
  input  logic                          blank,
  input  logic                          frame_start,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B,
  output logic                          pix_valid,
  output logic [NUM_LAYERS-1:0]         collision_mask,
  output logic                          collision_any
);

  // live bits track real pixels so post-reset garbage never reaches pix_valid
  logic                          s1_live;
  logic [NUM_LAYERS-1:0]         s1_valid;
  logic [NUM_LAYERS*INDEX_W-1:0] s1_index;
  logic                          s1_blank;
  logic                          s1_fs;

  logic                  s2_live;
  logic [NUM_LAYERS-1:0] s2_valid;
  logic                  s2_blank;
  logic                  s2_fs;
  color_t                s2_color [NUM_LAYERS];

  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] hit_mask;
  logic [3:0]            opaque_cnt;
  logic                  collide;
  color_t                sel_color;
  color_t                out_color;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_live  <= 1'b0;
      s1_valid <= '0;
      s1_index <= '0;
      s1_blank <= 1'b0;
      s1_fs    <= 1'b0;
      s2_live  <= 1'b0;
      s2_valid <= '0;
      s2_blank <= 1'b0;
      s2_fs    <= 1'b0;
    end else begin
      s1_live  <= 1'b1;
      s1_valid <= layer_valid;
      s1_index <= layer_index;
      s1_blank <= blank;
      s1_fs    <= frame_start;
      s2_live  <= s1_live;
      s2_valid <= s1_valid;
      s2_blank <= s1_blank;
      s2_fs    <= s1_fs;
    end
  end

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    palette_lut #(.INDEX_W(INDEX_W)) u_lut (
      .clk   (Clk),
      .rst_n (Reset_n),
      .index (s1_index[gi*INDEX_W +: INDEX_W]),
      .color (s2_color[gi])
    );
    assign opaque[gi] = s2_valid[gi] && (s2_color[gi] != TRANSPARENT_KEY);
  end

  // Walk from lowest to highest priority so layer 0 wins last.
  always_comb begin
    sel_color = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) sel_color = s2_color[i];
    end
  end

  always_comb begin
    opaque_cnt = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque_cnt = opaque_cnt + 4'(opaque[i]);
    end
  end

  assign collide  = s2_live && !s2_blank && (opaque_cnt >= 4'd2);
  assign hit_mask = collide ? opaque : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_color      <= '0;
      pix_valid      <= 1'b0;
      collision_mask <= '0;
    end else if (s2_live) begin
      out_color      <= s2_blank ? '0 : sel_color;
      pix_valid      <= !s2_blank;
      // frame start reloads with this pixel's own hits rather than clearing
      collision_mask <= s2_fs ? hit_mask : (collision_mask | hit_mask);
    end else begin
      out_color <= '0;
      pix_valid <= 1'b0;
    end
  end

  assign VGA_R         = out_color[23:16];
  assign VGA_G         = out_color[15:8];
  assign VGA_B         = out_color[7:0];
  assign collision_any = |collision_mask;

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 2: number of sprite layers; legal range 1..8; layer 0 has the highest priority.
REQ-002 Parameter INDEX_W, default 4: palette index width per layer.
REQ-003 Parameter TRANSPARENT_KEY, default 24'hF442EE: palette color treated as see-through.
REQ-004 Parameter BG_COLOR, default 24'h0000F0: color shown where no layer is opaque.
REQ-005 Port Clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 Port Reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port layer_valid, input, NUM_LAYERS: bit i high means layer i covers the current pixel.
REQ-008 Port layer_index, input, NUM_LAYERS x INDEX_W: palette index for each layer.
REQ-009 Port blank, input, 1: high marks a pixel outside the visible area.
REQ-010 Port frame_start, input, 1: one-cycle pulse, aligned with the first pixel of a frame.
REQ-011 Port VGA_R, VGA_G, VGA_B, output, 8 each: registered pixel color.
REQ-012 Port pix_valid, output, 1: high when the VGA_* outputs carry a visible pixel.
REQ-013 Port collision_mask, output, NUM_LAYERS: sticky per-layer collision flags.
REQ-014 Port collision_any, output, 1: OR of all collision_mask bits.

Function
REQ-015 Fixed latency of 3 Clk cycles, from input sample to VGA_*, pix_valid and collision update; it is identical for every pixel and every parameter value.
REQ-016 Stage 1: register layer_valid, layer_index, blank and frame_start.
REQ-017 Stage 2: one synchronous palette read per layer, with 1-cycle read latency; valid, blank and frame_start are delayed to stay aligned.
REQ-018 Stage 3, opacity: layer i is opaque when it is valid and its palette color is not TRANSPARENT_KEY.
REQ-019 Stage 3, color: output the color of the lowest-numbered opaque layer; if no layer is opaque, output BG_COLOR.
REQ-020 Stage 3, blanking: when blank is high, VGA_* are 0 and pix_valid is 0, whatever the layer state.
REQ-021 Collision event: two or more layers are opaque on a pixel that is not blanked.
REQ-022 On a collision event, set collision_mask bit i for every layer i that is opaque on that pixel.
REQ-023 Bits set by collision events are sticky until the next frame start.
REQ-024 Frame start: when the aligned frame_start reaches stage 3, collision_mask is loaded with that pixel's own collision bits only; this is a clear and set in the same cycle, not a plain clear.
REQ-025 Blanked pixels never set collision bits.
REQ-026 Valid-but-transparent layers never count toward a collision and never hide lower-priority layers.
REQ-027 Back-to-back pixels are accepted every cycle; there is no stall and no handshake.
REQ-028 With NUM_LAYERS=1, collision_mask stays 0 permanently.

Reset
REQ-029 While Reset_n is low, all pipeline registers clear asynchronously.
REQ-030 Reset values: VGA_*=0, pix_valid=0, collision_mask=0, collision_any=0.
REQ-031 After Reset_n deasserts, the first 3 output cycles show pix_valid=0.
REQ-032 A reset in mid-frame discards all in-flight pixels; no partial pixel reaches the outputs.

Structure
REQ-033 A shared package vga_pkg holds: the color typedef (24-bit, R in [23:16], G in [15:8], B in [7:0]), TRANSPARENT_KEY_DEF, BG_COLOR_DEF and the PIPE_LAT=3 constant.
REQ-034 Sub-module palette_lut: a synchronous single-read-port ROM, 2^INDEX_W x 24, instantiated once per layer.
REQ-035 The priority select is a parametrised loop; there is no hard-coded per-layer mux.

Verification
REQ-036 Priority: layer0 index 3 gives 24'hFF0000 and layer1 index 5 gives 24'h00FF00, both valid -> after 3 cycles VGA=FF/00/00, collision_mask=2'b11.
REQ-037 Transparency: layer0 index maps to F442EE and layer1 maps to 00FF00 -> VGA=00/FF/00, collision_mask unchanged.
REQ-038 Background: no layers valid -> VGA=00/00/F0, pix_valid=1.
REQ-039 Blanking: blank=1 with two opaque layers -> VGA=0, pix_valid=0, no collision bit set.
REQ-040 Frame start: collision latched in frame N; frame_start on a pixel with no overlap -> collision_mask=0; frame_start on an overlapping pixel -> collision_mask=2'b11 in the same cycle.
REQ-041 Reset mid-stream: drop Reset_n while pixels are in flight -> all outputs 0 immediately; 3 pix_valid=0 cycles follow release.
